if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage of the pipelined RV32I core.
- Accepts {instruction, PC, PC+4} tuples from fetch through a valid/ready handshake and presents the oldest one to decode.
- Squashes all buffered wrong-path instructions when a taken branch or jump resolves in execute.
- Replaces the plain IF/ID register so a decode stall no longer has to freeze the PC immediately.

Parameters:
WIDTH, 32, data/address width of instruction and PC fields
DEPTH, 2, number of entries; power of two, >= 2
NOP, 32'h00000013, instruction driven on InstrD when empty (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
flush  input  1  squash all entries; driven by PCSrcE
valid_f  input  1  fetch offers a tuple this cycle
InstrF  input  WIDTH  fetched instruction
PCF  input  WIDTH  PC of fetched instruction
PCPlus4F  input  WIDTH  PCF+4
ready_f  output  1  queue can accept (not full)
valid_d  output  1  head entry valid
InstrD  output  WIDTH  head instruction, NOP when empty
PCD  output  WIDTH  head PC, 0 when empty
PCPlus4D  output  WIDTH  head PC+4, 0 when empty
ready_d  input  1  decode consumes head this cycle (= !StallD)
count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous and active-low.
- Reset (rst=0, asynchronous): write/read pointers=0, count=0, valid_d=0, ready_f=1, InstrD=NOP, PCD=0, PCPlus4D=0. Storage contents don't-care.
- Enqueue fires on a rising edge when valid_f && ready_f && !flush. The tuple is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Dequeue fires on a rising edge when valid_d && ready_d && !flush. rd_ptr advances modulo DEPTH.
- ready_f = (count != DEPTH), combinational from count only. It does not depend on ready_d: no same-cycle pass-through when full.
- valid_d = (count != 0).
- InstrD/PCD/PCPlus4D are the entry at rd_ptr when valid_d; otherwise NOP/0/0.
- Latency: a tuple enqueued at edge N is visible on the D outputs after edge N when the queue was empty. There is no combinational bypass from F inputs to D outputs.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): both fire and count is unchanged.
- Empty: a dequeue cannot fire, so ready_d is ignored.
- Full: enqueue is blocked. valid_f with ready_f=0 is a fetch-side stall; fetch must hold PCF.
- Flush has priority over everything on its edge:
  - pointers=0, count=0;
  - the concurrent enqueue is dropped (wrong-path instruction);
  - the concurrent dequeue does not count as consumed.
  - The next cycle shows valid_d=0, InstrD=NOP, ready_f=1.
- Flush while empty: no effect beyond pointer reset.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count, never by pointer comparison.
- count is never outside 0..DEPTH. Assertion: no enqueue when full, no dequeue when empty.
- Reset asserted mid-operation clears everything asynchronously. Outputs take their reset values within the same cycle, without waiting for a clock edge.

Test Plan:
1. Reset then stream:
   - Stimulus: rst low 3 cycles, then high; valid_f=1, ready_d=1; PCF=0,4,8 with InstrF=A,B,C.
   - Required: valid_d rises one cycle after the first enqueue; D outputs show A/0/4, B/4/8, C/8/12 on consecutive cycles; count stays at 1.
2. Fill and stall:
   - Stimulus: ready_d=0, enqueue 0x00500093 at PC 0 and 0x00A00113 at PC 4.
   - Required: count=2, ready_f=0; a third offer (PC 8) is not accepted. Release ready_d: entries drain in order; the PC 8 tuple is accepted the cycle after count drops to 1.
3. Flush with concurrent traffic:
   - Stimulus: count=2, valid_f=1 (PC 0x10), ready_d=1, flush=1 for one cycle.
   - Required: next cycle count=0, valid_d=0, InstrD=0x00000013, PCD=0, ready_f=1. The PC 0x10 tuple never appears.
4. Wrap-around:
   - Stimulus: DEPTH=2, 7 enqueue/dequeue pairs with alternating ready_d patterns.
   - Required: PC order 0,4,...,24 preserved exactly; count never exceeds 2.
5. Asynchronous reset mid-operation:
   - Stimulus: count=2, drop rst between clock edges.
   - Required: valid_d=0, count=0, InstrD=NOP immediately, before the next edge.
6. Empty with ready_d high:
   - Stimulus: empty queue, ready_d=1 for 5 cycles, valid_f=0.
   - Required: count stays 0, D outputs stay NOP/0/0, no underflow assertion fires.

Source files
------------

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the IF/ID decoupling queue.
//   flush                        squash all buffered entries (PCSrcE)
//   valid_f/ready_f + InstrF/PCF/PCPlus4F    fetch-side offer
//   valid_d/ready_d + InstrD/PCD/PCPlus4D    decode-side head
//   count                        occupancy, 0..DEPTH
// slave = the queue, master = whoever drives fetch and decode.
interface if_id_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             valid_f;
  logic [WIDTH-1:0] InstrF;
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] PCPlus4F;
  logic             ready_f;
  logic             valid_d;
  logic [WIDTH-1:0] InstrD;
  logic [WIDTH-1:0] PCD;
  logic [WIDTH-1:0] PCPlus4D;
  logic             ready_d;
  logic [CW-1:0]    count;

  modport slave (
    input  flush, valid_f, InstrF, PCF, PCPlus4F, ready_d,
    output ready_f, valid_d, InstrD, PCD, PCPlus4D, count
  );

  modport master (
    output flush, valid_f, InstrF, PCF, PCPlus4F, ready_d,
    input  ready_f, valid_d, InstrD, PCD, PCPlus4D, count
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: small FIFO between fetch and decode of the RV32I pipeline.
// Holds {instr, pc, pc+4} tuples; head is presented to decode, NOP/0/0 when
// empty. A flush (taken branch/jump in execute) drops everything, including
// a tuple offered on the same edge.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   q    if_id_queue_if.slave (see interface header)
module if_id_queue #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
  input logic           clk,
  input logic           rst,
  if_id_queue_if.slave  q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          enq, deq;

  // Full/empty come from the occupancy counter only; ready_f deliberately
  // ignores ready_d so there is no fall-through path when full.
  assign q.ready_f = (cnt != FULL);
  assign q.valid_d = (cnt != '0);
  assign q.count   = cnt;

  assign enq = q.valid_f && q.ready_f && !q.flush;
  assign deq = q.valid_d && q.ready_d && !q.flush;

  // Power-of-two DEPTH: pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: nothing is read unless count says it is valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{instr: q.InstrF, pc: q.PCF, pc4: q.PCPlus4F};
  end

  entry_t head;
  assign head = mem[rd_ptr];

  // Gated by valid_d so an async reset forces NOP/0/0 without a clock edge.
  assign q.InstrD   = q.valid_d ? head.instr : NOP;
  assign q.PCD      = q.valid_d ? head.pc    : '0;
  assign q.PCPlus4D = q.valid_d ? head.pc4   : '0;

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt <= FULL);
  a_no_ovf:    assert property (@(posedge clk) disable iff (!rst) enq |-> cnt != FULL);
  a_no_udf:    assert property (@(posedge clk) disable iff (!rst) deq |-> cnt != '0);
endmodule
